// File: rtl/spike_event_feeder_pkg.sv
// Shared types and width helpers for the spike event feeder and the conv layer it drives.
// Package name is snn_feeder_pkg so the conv layer can import the same width helpers.
package snn_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    LOAD       = 3'd2,
    SCAN       = 3'd3,
    TS_END     = 3'd4,
    WAIT_LAYER = 3'd5,
    DONE       = 3'd6
  } feeder_state_e;

  // Index width that stays at least one bit wide for degenerate sizes of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int frame_addr_w(input int fw, input int ic, input int ts);
    return idx_w(fw * ic * ts);
  endfunction

  function automatic int spike_cnt_w(input int ic, input int fw);
    return $clog2(ic * fw * fw + 1);
  endfunction

endpackage

// File: rtl/spike_event_feeder_if.sv
// Address-event handshake bus between the spike feeder (master) and conv_1_1 (slave).
interface spike_event_feeder_if #(
  parameter int FRAME_WIDTH    = 32,
  parameter int INPUT_CHANNELS = 3
);
  logic                                                ev_valid;
  logic                                                ev_ready;
  logic [snn_feeder_pkg::idx_w(INPUT_CHANNELS)-1:0]    ev_ch;
  logic [snn_feeder_pkg::idx_w(FRAME_WIDTH)-1:0]       ev_row;
  logic [snn_feeder_pkg::idx_w(FRAME_WIDTH)-1:0]       ev_col;

  modport master (output ev_valid, output ev_ch, output ev_row, output ev_col, input ev_ready);
  modport slave  (input ev_valid, input ev_ch, input ev_row, input ev_col, output ev_ready);
endinterface

// File: rtl/spike_event_feeder_prienc.sv
// Combinational lowest-set-bit encoder for one spike row word; also flags
// whether any bit is set and whether exactly one bit remains.
module spike_row_prienc #(
  parameter int W = 32
) (
  input  logic [W-1:0]                         vec,
  output logic [snn_feeder_pkg::idx_w(W)-1:0]  idx,
  output logic                                 any,
  output logic                                 one_left
);
  import snn_feeder_pkg::*;

  localparam int IW = idx_w(W);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign any      = |vec;
  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign one_left = any && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/spike_event_feeder.sv
// Reads dense binary spike rows from frame memory and emits sparse (ch,row,col) events,
// one timestep at a time, handshaking with the conv layer via input_avail/layer_avail.
// Optional per-timestep accepted-event counter: define SPIKE_FEEDER_STATS_EN.
module spike_event_feeder #(
  parameter int FRAME_WIDTH    = 32,
  parameter int INPUT_CHANNELS = 3,
  parameter int TIMESTEPS      = 4,
  parameter int ADDR_W         = $clog2(TIMESTEPS * INPUT_CHANNELS * FRAME_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [FRAME_WIDTH-1:0]  rd_data,
  spike_event_feeder_if.master    ev,
  output logic                    input_avail,
  input  logic                    layer_avail,
  output logic                    busy,
  output logic                    done
`ifdef SPIKE_FEEDER_STATS_EN
  ,
  output logic [snn_feeder_pkg::spike_cnt_w(INPUT_CHANNELS, FRAME_WIDTH)-1:0] ts_spike_cnt
`endif
);
  import snn_feeder_pkg::*;

  localparam int CH_W  = idx_w(INPUT_CHANNELS);
  localparam int POS_W = idx_w(FRAME_WIDTH);
  localparam int TS_W  = idx_w(TIMESTEPS);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_FETCH  = FETCH;
  localparam logic [2:0] ST_LOAD   = LOAD;
  localparam logic [2:0] ST_SCAN   = SCAN;
  localparam logic [2:0] ST_TS_END = TS_END;
  localparam logic [2:0] ST_WAIT   = WAIT_LAYER;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(FRAME_WIDTH - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(INPUT_CHANNELS - 1);
  localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(TIMESTEPS - 1);

  logic [2:0]             state_q, state_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [POS_W-1:0]       row_q, row_d;
  logic [FRAME_WIDTH-1:0] row_reg_q, row_reg_d;

  logic [POS_W-1:0]       low_idx;
  logic                   row_any;
  logic                   row_one;
  logic                   accept;
  logic [ADDR_W-1:0]      addr_c;

  spike_row_prienc #(.W(FRAME_WIDTH)) u_prienc (
    .vec      (row_reg_q),
    .idx      (low_idx),
    .any      (row_any),
    .one_left (row_one)
  );

  assign accept = ev.ev_valid && ev.ev_ready;
  assign addr_c = ADDR_W'((int'(ts_q) * INPUT_CHANNELS + int'(ch_q)) * FRAME_WIDTH + int'(row_q));

  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    ch_d      = ch_q;
    row_d     = row_q;
    row_reg_d = row_reg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ts_d    = '0;
          ch_d    = '0;
          row_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        row_reg_d = rd_data;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        // An empty row, or accepting its final spike, moves straight on to the next row.
        if (!row_any || (accept && row_one)) begin
          row_reg_d = '0;
          if (row_q != LAST_ROW) begin
            row_d   = row_q + POS_W'(1);
            state_d = ST_FETCH;
          end else begin
            row_d = '0;
            if (ch_q != LAST_CH) begin
              ch_d    = ch_q + CH_W'(1);
              state_d = ST_FETCH;
            end else begin
              ch_d    = '0;
              state_d = ST_TS_END;
            end
          end
        end else if (accept) begin
          row_reg_d = row_reg_q & (row_reg_q - FRAME_WIDTH'(1));
        end
      end
      ST_TS_END: state_d = ST_WAIT;
      ST_WAIT: begin
        if (layer_avail) begin
          if (ts_q == LAST_TS) begin
            state_d = ST_DONE;
          end else begin
            ts_d    = ts_q + TS_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        ts_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ts_q      <= '0;
      ch_q      <= '0;
      row_q     <= '0;
      row_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      ch_q      <= ch_d;
      row_q     <= row_d;
      row_reg_q <= row_reg_d;
    end
  end

  assign rd_en       = (state_q == ST_FETCH);
  assign rd_addr     = rd_en ? addr_c : '0;
  assign ev.ev_valid = (state_q == ST_SCAN) && row_any;
  assign ev.ev_ch    = ev.ev_valid ? ch_q : '0;
  assign ev.ev_row   = ev.ev_valid ? row_q : '0;
  assign ev.ev_col   = ev.ev_valid ? low_idx : '0;
  assign input_avail = (state_q == ST_TS_END);
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef SPIKE_FEEDER_STATS_EN
  localparam int CNT_W = spike_cnt_w(INPUT_CHANNELS, FRAME_WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Count restarts with the first fetch of a timestep; holds through TS_END and the wait.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_FETCH && row_q == '0 && ch_q == '0) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ts_spike_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_feeder.sv
// Scoreboard bench for spike_event_feeder: a frame-level reference model predicts the
// event stream, read addresses and per-timestep counts; a negedge monitor checks them.
module tb_spike_event_feeder;
  import snn_feeder_pkg::*;

  localparam int FW = 32;
  localparam int IC = 3;
  localparam int TS = 4;
  localparam int AW = $clog2(TS * IC * FW);
  localparam int NW = TS * IC * FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [FW-1:0] rd_data = '0;
  logic          input_avail;
  logic          layer_avail = 1'b0;
  logic          busy;
  logic          done;
`ifdef SPIKE_FEEDER_STATS_EN
  logic [spike_cnt_w(IC, FW)-1:0] ts_spike_cnt;
`endif

  spike_event_feeder_if #(.FRAME_WIDTH(FW), .INPUT_CHANNELS(IC)) ev_if ();

  spike_event_feeder #(
    .FRAME_WIDTH(FW), .INPUT_CHANNELS(IC), .TIMESTEPS(TS), .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .ev          (ev_if),
    .input_avail (input_avail),
    .layer_avail (layer_avail),
    .busy        (busy),
    .done        (done)
`ifdef SPIKE_FEEDER_STATS_EN
    ,
    .ts_spike_cnt(ts_spike_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [FW-1:0] mem [NW];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model state
  int exp_ev[$];
  int exp_addr[$];
  int exp_cnt[TS];
  int ia_idx, acc_cnt, done_cnt, cyc;
  int rd_cyc[$];
  int ia_cyc[$];
  int ready_mode = 0;
  int layer_delay = 0;
  int lcnt = 0;
  bit waiting = 1'b0;
  bit stall = 1'b0;
  int stall_pay = 0;

  function automatic int pack_ev(input int ch, input int row, input int col);
    return (ch << 16) | (row << 8) | col;
  endfunction

  task automatic build_model();
    exp_ev.delete();
    exp_addr.delete();
    for (int t = 0; t < TS; t++) begin
      exp_cnt[t] = 0;
      for (int c = 0; c < IC; c++)
        for (int r = 0; r < FW; r++) begin
          int a;
          a = (t * IC + c) * FW + r;
          exp_addr.push_back(a);
          for (int col = 0; col < FW; col++)
            if (mem[a][col]) begin
              exp_ev.push_back(pack_ev(c, r, col));
              exp_cnt[t]++;
            end
        end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NW; i++) mem[i] = '0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NW; i++) mem[i] = $urandom & $urandom & $urandom;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input drivers: ready backpressure and the layer's availability level.
  initial begin
    ev_if.ev_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ev_if.ev_ready = (ready_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rst) begin
        waiting = 1'b0;
        layer_avail = 1'b0;
      end else if (input_avail) begin
        layer_avail = 1'b0;
        waiting = 1'b1;
        lcnt = layer_delay;
      end else if (waiting) begin
        if (lcnt == 0) begin
          layer_avail = 1'b1;
          waiting = 1'b0;
        end else lcnt--;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    int pay;
    pay = pack_ev(int'(ev_if.ev_ch), int'(ev_if.ev_row), int'(ev_if.ev_col));
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", ev_if.ev_valid, 1);
        chk("hold_payload", pay, stall_pay);
      end
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (exp_ev.size() == 0) chk("unexpected_event", pay, -1);
        else chk("event", pay, exp_ev.pop_front());
        acc_cnt++;
      end
      stall = ev_if.ev_valid && !ev_if.ev_ready;
      stall_pay = pay;
      if (waiting) chk("rd_while_layer_low", rd_en, 0);
      if (rd_en) begin
        rd_cyc.push_back(cyc);
        if (exp_addr.size() == 0) chk("unexpected_rd", rd_addr, -1);
        else chk("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (input_avail) begin
        ia_cyc.push_back(cyc);
        if (ia_idx < TS) begin
          chk("ts_events", acc_cnt, exp_cnt[ia_idx]);
`ifdef SPIKE_FEEDER_STATS_EN
          chk("ts_spike_cnt", ts_spike_cnt, exp_cnt[ia_idx]);
`endif
        end else chk("extra_input_avail", ia_idx, TS - 1);
        acc_cnt = 0;
        ia_idx++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_inference(input int rmode, input int ldelay, input string name);
    int n;
    ready_mode = rmode;
    layer_delay = ldelay;
    build_model();
    ia_idx = 0;
    acc_cnt = 0;
    done_cnt = 0;
    rd_cyc.delete();
    ia_cyc.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_ev_left"}, exp_ev.size(), 0);
    chk({name, "_rd_left"}, exp_addr.size(), 0);
    chk({name, "_ia_pulses"}, ia_idx, TS);
    chk({name, "_busy_idle"}, busy, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_rd_en"}, rd_en, 0);
    chk({name, "_rd_addr"}, rd_addr, 0);
    chk({name, "_ev_valid"}, ev_if.ev_valid, 0);
    chk({name, "_ev_payload"}, pack_ev(int'(ev_if.ev_ch), int'(ev_if.ev_row), int'(ev_if.ev_col)), 0);
    chk({name, "_input_avail"}, input_avail, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
`ifdef SPIKE_FEEDER_STATS_EN
    chk({name, "_ts_spike_cnt"}, ts_spike_cnt, 0);
`endif
  endtask

  initial begin
    int n;
    clear_mem();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single spike at ts0,ch1,row5,col7
    clear_mem();
    mem[(0 * IC + 1) * FW + 5] = 32'h0000_0080;
    run_inference(0, 0, "single");

    // Full row: 32 back-to-back events, 34-cycle row
    clear_mem();
    mem[0] = 32'hFFFF_FFFF;
    run_inference(0, 0, "fullrow");
    if (rd_cyc.size() >= 2) chk("fullrow_cycles", rd_cyc[1] - rd_cyc[0], 34);
    else chk("fullrow_rd_count", rd_cyc.size(), 2);

    // All-zero frame: 96 empty rows of 3 cycles each
    clear_mem();
    run_inference(0, 0, "zero");
    if (rd_cyc.size() >= 1 && ia_cyc.size() >= 1) chk("zero_ts_cycles", ia_cyc[0] - rd_cyc[0], 288);
    else chk("zero_ia_count", ia_cyc.size(), TS);

    // Random frames under random backpressure
    for (int k = 0; k < 2; k++) begin
      rand_mem();
      run_inference(1, k, "random");
    end

    // Layer availability delayed by 50 cycles after each input_avail
    rand_mem();
    run_inference(1, 50, "layer_delay");
    if (rd_cyc.size() > IC * FW && ia_cyc.size() >= 1)
      chk("layer_gap", rd_cyc[IC * FW] - ia_cyc[0], 52);
    else chk("layer_rd_count", rd_cyc.size(), NW);

    // Ten spikes in timestep 0 (stats counter check when enabled)
    clear_mem();
    n = 0;
    while (n < 10) begin
      int a, b;
      a = $urandom_range(0, IC * FW - 1);
      b = $urandom_range(0, FW - 1);
      if (!mem[a][b]) begin
        mem[a][b] = 1'b1;
        n++;
      end
    end
    run_inference(1, 2, "ten_spikes");

    // Reset in the middle of SCAN, then a clean restart
    rand_mem();
    mem[5] = 32'h0F0F_0F0F;
    build_model();
    ready_mode = 1;
    layer_delay = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!ev_if.ev_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midscan_ev_valid_seen", ev_if.ev_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("midscan_rst");
    exp_ev.delete();
    exp_addr.delete();
    @(posedge clk); #1 rst = 1'b0;
    rand_mem();
    run_inference(1, 1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
